// File: rtl/cntry_rd_sensor_pkg.sv
// Shared definitions for the country-road sensor and the highway/country-road
// signal controller: boolean constants, the one-hot signal encodings and the
// loop debounce state encoding.
package cntry_rd_sensor_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // One-hot lamp encodings driven by the controller
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    // Decoded signal aspect; anything that is not a legal one-hot code is RED
    typedef enum logic [1:0] {
        SIG_RED    = 2'd0,
        SIG_YELLOW = 2'd1,
        SIG_GREEN  = 2'd2
    } sig_t;

    // Loop debounce FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_PRESENT   = 2'd2,
        ST_FALL_WAIT = 2'd3
    } deb_state_t;

    function automatic sig_t sig_decode(input logic [2:0] sig);
        case (sig)
            GREEN:   return SIG_GREEN;
            YELLOW:  return SIG_YELLOW;
            RED:     return SIG_RED;
            default: return SIG_RED;   // 3'b000 or multi-hot: fail safe to RED
        endcase
    endfunction

endpackage

// File: rtl/cntry_rd_sensor_loop_debounce.sv
// Loop detector debounce: accepts a loop edge after DEBOUNCE agreeing samples,
// emits a one-cycle arrival pulse on each accepted rising edge, and flags a
// loop that stays present for STUCK_CYCLES cycles.
module cntry_rd_sensor_loop_debounce
    import cntry_rd_sensor_pkg::*;
#(
    parameter int DEBOUNCE     = 2,
    parameter int STUCK_CYCLES = 30
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_loop_det,
    output logic o_arr,
    output logic o_loop_fault,
    output logic o_fault_nxt
);

    localparam logic [2:0] DB        = 3'(DEBOUNCE);
    localparam logic [7:0] STUCK_MAX = 8'(STUCK_CYCLES);
    localparam logic [7:0] STUCK_SET = 8'(STUCK_CYCLES - 1);

    deb_state_t r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_stuck;
    logic       r_arr;
    logic       r_fault;

    logic w_rise_done;
    logic w_fall_done;
    logic w_fault_set;
    logic w_fault_nxt;

    // Current sample completes a qualifying high (low) run this edge
    assign w_rise_done = i_loop_det &&
                         ((r_state == ST_IDLE && DB == 3'd1) ||
                          (r_state == ST_RISE_WAIT && (r_cnt + 3'd1) == DB));
    assign w_fall_done = !i_loop_det &&
                         ((r_state == ST_PRESENT && DB == 3'd1) ||
                          (r_state == ST_FALL_WAIT && (r_cnt + 3'd1) == DB));

    // Fault sets on the edge the stuck counter reaches its limit and clears on
    // the edge the loop is accepted as released (entering IDLE); release wins.
    assign w_fault_set = (r_state == ST_PRESENT) && (r_stuck == STUCK_SET);
    assign w_fault_nxt = !w_fall_done && (r_fault || w_fault_set);

    // Debounce FSM with its sample counter and the registered arrival pulse
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_arr   <= FALSE;
        end else begin
            r_arr <= FALSE;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise_done) begin
                        r_state <= ST_PRESENT;
                        r_arr   <= TRUE;
                        r_cnt   <= '0;
                    end else if (i_loop_det) begin
                        r_state <= ST_RISE_WAIT;
                        r_cnt   <= 3'd1;
                    end
                end
                ST_RISE_WAIT: begin
                    if (!i_loop_det) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_rise_done) begin
                        r_state <= ST_PRESENT;
                        r_arr   <= TRUE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_PRESENT: begin
                    if (w_fall_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (!i_loop_det) begin
                        r_state <= ST_FALL_WAIT;
                        r_cnt   <= 3'd1;
                    end
                end
                ST_FALL_WAIT: begin
                    if (i_loop_det) begin
                        // Bounce back to PRESENT is the same car: no arrival
                        r_state <= ST_PRESENT;
                        r_cnt   <= '0;
                    end else if (w_fall_done) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stuck-loop watchdog: count cycles spent in PRESENT, hold at the limit
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_stuck <= '0;
            r_fault <= FALSE;
        end else begin
            if (r_state == ST_PRESENT) begin
                if (r_stuck != STUCK_MAX) begin
                    r_stuck <= r_stuck + 8'd1;
                end
            end else begin
                r_stuck <= '0;
            end
            r_fault <= w_fault_nxt;
        end
    end

    assign o_arr        = r_arr;
    assign o_loop_fault = r_fault;
    // Look-ahead so the request register can update on the same edge as the flag
    assign o_fault_nxt  = !i_clear && w_fault_nxt;

endmodule

// File: rtl/cntry_rd_sensor.sv
// Country-road vehicle sensor: counts debounced loop arrivals, retires one car
// per DEPART_CYCLES green cycles, and requests the green while cars wait or
// the loop is faulted.
module cntry_rd_sensor
    import cntry_rd_sensor_pkg::*;
#(
    parameter int DEBOUNCE      = 2,
    parameter int DEPART_CYCLES = 3,
    parameter int QW            = 3,
    parameter int QMAX          = 7,
    parameter int STUCK_CYCLES  = 30
) (
    input  logic          CLOCK,
    input  logic          CLEAR,
    input  logic          LOOP_DET,
    input  logic [2:0]    CNTRY_SIG,
    output logic          CAR_ON_CNTRY_RD,
    output logic [QW-1:0] QUEUE_CNT,
    output logic          QUEUE_FULL,
    output logic          LOOP_FAULT
);

    localparam logic [QW-1:0] Q_MAX    = QW'(QMAX);
    localparam logic [3:0]    DEP_LAST = 4'(DEPART_CYCLES);

    logic          w_arr;
    logic          w_fault_nxt;
    logic          w_green;
    logic          w_queue_busy;
    logic [QW-1:0] w_queue_nxt;

    logic [3:0]    r_dep_cnt;
    logic          r_dep;
    logic [QW-1:0] r_queue;
    logic          r_full;
    logic          r_car;

    cntry_rd_sensor_loop_debounce #(
        .DEBOUNCE     (DEBOUNCE),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_loop_debounce (
        .i_clk        (CLOCK),
        .i_clear      (CLEAR),
        .i_loop_det   (LOOP_DET),
        .o_arr        (w_arr),
        .o_loop_fault (LOOP_FAULT),
        .o_fault_nxt  (w_fault_nxt)
    );

    assign w_green      = (sig_decode(CNTRY_SIG) == SIG_GREEN);
    assign w_queue_busy = (r_queue != '0);

    // Departure timer: one DEP pulse per DEPART_CYCLES green cycles with cars waiting
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            r_dep_cnt <= '0;
            r_dep     <= FALSE;
        end else if (w_green && w_queue_busy) begin
            if ((r_dep_cnt + 4'd1) == DEP_LAST) begin
                r_dep_cnt <= '0;
                r_dep     <= TRUE;
            end else begin
                r_dep_cnt <= r_dep_cnt + 4'd1;
                r_dep     <= FALSE;
            end
        end else begin
            r_dep_cnt <= '0;
            r_dep     <= FALSE;
        end
    end

    // Next queue depth from the registered arrival/departure pulses
    // NOTE: default assignment first so every path drives w_queue_nxt (no latch).
    always_comb begin
        w_queue_nxt = r_queue;
        if (w_arr && !r_dep) begin
            if (r_queue != Q_MAX) begin
                w_queue_nxt = r_queue + QW'(1);
            end
        end else if (r_dep && !w_arr) begin
            if (r_queue != '0) begin
                w_queue_nxt = r_queue - QW'(1);
            end
        end
    end

    // Output registers all updated together with the queue depth
    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            r_queue <= '0;
            r_full  <= FALSE;
            r_car   <= FALSE;
        end else begin
            r_queue <= w_queue_nxt;
            r_full  <= (w_queue_nxt == Q_MAX);
            r_car   <= (w_queue_nxt != '0) || w_fault_nxt;
        end
    end

    assign QUEUE_CNT       = r_queue;
    assign QUEUE_FULL      = r_full;
    assign CAR_ON_CNTRY_RD = r_car;

endmodule

// File: tb/tb_cntry_rd_sensor.sv
// Self-checking bench for cntry_rd_sensor: a table of directed vectors, a few
// hand-written multi-cycle sequences, and a randomized run against a
// behavioural model of the sensor.
module tb_cntry_rd_sensor;

    localparam int DEBOUNCE      = 2;
    localparam int DEPART_CYCLES = 3;
    localparam int QW            = 3;
    localparam int QMAX          = 7;
    localparam int STUCK_CYCLES  = 30;

    localparam logic [2:0] S_RED = 3'b100;
    localparam logic [2:0] S_YEL = 3'b010;
    localparam logic [2:0] S_GRN = 3'b001;

    logic          CLOCK = 1'b0;
    logic          CLEAR;
    logic          LOOP_DET;
    logic [2:0]    CNTRY_SIG;
    logic          CAR_ON_CNTRY_RD;
    logic [QW-1:0] QUEUE_CNT;
    logic          QUEUE_FULL;
    logic          LOOP_FAULT;

    cntry_rd_sensor #(
        .DEBOUNCE      (DEBOUNCE),
        .DEPART_CYCLES (DEPART_CYCLES),
        .QW            (QW),
        .QMAX          (QMAX),
        .STUCK_CYCLES  (STUCK_CYCLES)
    ) dut (
        .CLOCK           (CLOCK),
        .CLEAR           (CLEAR),
        .LOOP_DET        (LOOP_DET),
        .CNTRY_SIG       (CNTRY_SIG),
        .CAR_ON_CNTRY_RD (CAR_ON_CNTRY_RD),
        .QUEUE_CNT       (QUEUE_CNT),
        .QUEUE_FULL      (QUEUE_FULL),
        .LOOP_FAULT      (LOOP_FAULT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_vec  = 0;
    int n_miss = 0;

    // Behavioural model: the accepted loop level flips once the last DEBOUNCE
    // raw samples all disagree with it; arrivals and departures are pulses
    // that land in the queue one edge later.
    int m_q;
    bit m_arr;
    bit m_dep;
    int m_green_run;
    bit m_present;
    bit m_last;
    bit m_hist [DEBOUNCE];
    int m_stuck;
    bit m_fault;

    typedef struct {
        bit         clr;
        bit         loop;
        logic [2:0] sig;
        int         q;
        bit         car;
        bit         full;
        bit         fault;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit clr, input bit loop, input logic [2:0] sig);
        int old_q;
        bit old_arr;
        bit old_dep;
        bit old_present;
        bit was_present_state;
        bit all_flip;
        if (clr) begin
            m_q = 0; m_arr = 0; m_dep = 0; m_green_run = 0;
            m_present = 0; m_last = 0; m_stuck = 0; m_fault = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
            return;
        end
        old_q       = m_q;
        old_arr     = m_arr;
        old_dep     = m_dep;
        old_present = m_present;
        // Loop is "present and still high" (not in a pending release)
        was_present_state = m_present && m_last;

        if (old_arr && !old_dep)      m_q = (old_q < QMAX) ? old_q + 1 : old_q;
        else if (old_dep && !old_arr) m_q = (old_q > 0) ? old_q - 1 : 0;

        m_dep = 0;
        if (sig == S_GRN && old_q > 0) begin
            m_green_run++;
            if (m_green_run == DEPART_CYCLES) begin
                m_dep       = 1;
                m_green_run = 0;
            end
        end else begin
            m_green_run = 0;
        end

        for (int i = DEBOUNCE - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = loop;
        m_last    = loop;
        all_flip  = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_present) all_flip = 0;
        if (all_flip) m_present = !m_present;
        m_arr = m_present && !old_present;

        if (was_present_state) begin
            if (m_stuck < STUCK_CYCLES) m_stuck++;
            if (m_stuck == STUCK_CYCLES) m_fault = 1;
        end else begin
            m_stuck = 0;
        end
        if (old_present && !m_present) m_fault = 0;
    endtask

    task automatic step(input bit clr, input bit loop, input logic [2:0] sig);
        CLEAR     = clr;
        LOOP_DET  = loop;
        CNTRY_SIG = sig;
        @(posedge CLOCK);
        #1;
        model_edge(clr, loop, sig);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},     8'(QUEUE_CNT),       8'(m_q));
        check({tag, ".full"},  8'(QUEUE_FULL),      8'(m_q == QMAX));
        check({tag, ".fault"}, 8'(LOOP_FAULT),      8'(m_fault));
        check({tag, ".car"},   8'(CAR_ON_CNTRY_RD), 8'((m_q != 0) || m_fault));
    endtask

    // One clean loop pulse: 3 high samples then 3 low samples
    task automatic pulse(input logic [2:0] sig, input string tag);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, (k < 3), sig);
            check_model(tag);
        end
    endtask

    initial begin
        int  exp_q;
        int  run_left;
        int  sig_left;
        bit  lvl;
        logic [2:0] rsig;

        CLEAR = 1'b1; LOOP_DET = 1'b0; CNTRY_SIG = S_RED;

        // Directed table: clear with loop high under green, release, mid-run
        // clear, then a one-cycle glitch under red.
        tbl[0]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, S_GRN, 1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, S_GRN, 0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, S_RED, 0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, S_RED, 0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, S_RED, 0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, S_RED, 0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].clr, tbl[i].loop, tbl[i].sig);
            check($sformatf("tbl[%0d].q", i),     8'(QUEUE_CNT),       8'(tbl[i].q));
            check($sformatf("tbl[%0d].car", i),   8'(CAR_ON_CNTRY_RD), 8'(tbl[i].car));
            check($sformatf("tbl[%0d].full", i),  8'(QUEUE_FULL),      8'(tbl[i].full));
            check($sformatf("tbl[%0d].fault", i), 8'(LOOP_FAULT),      8'(tbl[i].fault));
        end

        // Three cars under red, then drain under green: one every 3 cycles
        step(1'b1, 1'b0, S_RED);
        for (int p = 0; p < 3; p++) pulse(S_RED, "t3.fill");
        check("t3.q3", 8'(QUEUE_CNT), 8'd3);
        check("t3.car_on", 8'(CAR_ON_CNTRY_RD), 8'd1);
        for (int g = 1; g <= 10; g++) begin
            step(1'b0, 1'b0, S_GRN);
            exp_q = 3 - int'(g >= 4) - int'(g >= 7) - int'(g >= 10);
            check($sformatf("t3.drain%0d.q", g),   8'(QUEUE_CNT),       8'(exp_q));
            check($sformatf("t3.drain%0d.car", g), 8'(CAR_ON_CNTRY_RD), 8'(exp_q != 0));
        end

        // Saturation at QMAX, then one departure
        step(1'b1, 1'b0, S_RED);
        for (int p = 0; p < 10; p++) pulse(S_RED, "t4.fill");
        check("t4.sat.q", 8'(QUEUE_CNT), 8'd7);
        check("t4.sat.full", 8'(QUEUE_FULL), 8'd1);
        for (int g = 1; g <= 4; g++) begin
            step(1'b0, 1'b0, S_GRN);
            check_model("t4.dep");
        end
        check("t4.dep.q", 8'(QUEUE_CNT), 8'd6);
        check("t4.dep.full", 8'(QUEUE_FULL), 8'd0);

        // Arrival and departure registered on the same edge with two queued
        step(1'b1, 1'b0, S_RED);
        pulse(S_RED, "t5.fill");
        pulse(S_RED, "t5.fill");
        step(1'b0, 1'b0, S_GRN); check("t5.g1.q", 8'(QUEUE_CNT), 8'd2);
        step(1'b0, 1'b1, S_GRN); check("t5.g2.q", 8'(QUEUE_CNT), 8'd2);
        step(1'b0, 1'b1, S_GRN); check("t5.g3.q", 8'(QUEUE_CNT), 8'd2);
        step(1'b0, 1'b0, S_GRN); check("t5.both.q", 8'(QUEUE_CNT), 8'd2);
        step(1'b0, 1'b0, S_GRN);
        step(1'b0, 1'b0, S_GRN);
        step(1'b0, 1'b0, S_GRN); check("t5.after.q", 8'(QUEUE_CNT), 8'd1);

        // Stuck loop under green: fault after 30 cycles in PRESENT, clears on release
        step(1'b1, 1'b0, S_GRN);
        for (int e = 1; e <= 40; e++) begin
            step(1'b0, 1'b1, S_GRN);
            check($sformatf("t6.e%0d.fault", e), 8'(LOOP_FAULT), 8'(e >= 32));
            check($sformatf("t6.e%0d.car", e), 8'(CAR_ON_CNTRY_RD),
                  8'((e >= 3 && e <= 6) || e >= 32));
        end
        step(1'b0, 1'b0, S_GRN);
        check("t6.rel1.fault", 8'(LOOP_FAULT), 8'd1);
        check("t6.rel1.car", 8'(CAR_ON_CNTRY_RD), 8'd1);
        step(1'b0, 1'b0, S_GRN);
        check("t6.rel2.fault", 8'(LOOP_FAULT), 8'd0);
        check("t6.rel2.car", 8'(CAR_ON_CNTRY_RD), 8'd0);

        // Randomized run against the model, including illegal signal codes
        step(1'b1, 1'b0, S_RED);
        check_model("rnd.clr");
        run_left = 0; sig_left = 0; lvl = 1'b0; rsig = S_RED;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                lvl      = !lvl;
                run_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 45))
                                                       : int'($urandom_range(1, 6));
            end
            if (sig_left == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    rsig = S_GRN;
                    2:       rsig = S_RED;
                    3:       rsig = S_YEL;
                    default: rsig = 3'($urandom_range(0, 7));
                endcase
                sig_left = int'($urandom_range(1, 15));
            end
            step(($urandom_range(0, 299) == 0), lvl, rsig);
            check_model("rnd");
            run_left--;
            sig_left--;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
